rtx_fb_writer: RTL
==================

RTX_FB_WRITER -- requirements
Module: rtx_fb_writer

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 1280, horizontal pixel count.
REQ-002 The block SHALL have parameter HEIGHT, default 720, vertical pixel count.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, power of two >= 2, pixel entries buffered.
REQ-004 The block SHALL have parameter ADDR_W, default 20, framebuffer word-address width, at least clog2(WIDTH*HEIGHT).

Interface
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset (0 = in reset).
REQ-007 The block SHALL have port rtx_pixel, input, 16 bits, 565 color: [15:11] b, [10:5] g, [4:0] r.
REQ-008 The block SHALL have port pixel_h, input, 11 bits, column of rtx_pixel.
REQ-009 The block SHALL have port pixel_v, input, 10 bits, row of rtx_pixel.
REQ-010 The block SHALL have port ray_done, input, 1 bit, one-cycle pixel-valid strobe; there is no backpressure.
REQ-011 The block SHALL have port fb_addr, output, ADDR_W bits, write address.
REQ-012 The block SHALL have port fb_data, output, 16 bits, write data.
REQ-013 The block SHALL have port fb_we, output, 1 bit, write request.
REQ-014 The block SHALL have port fb_ready, input, 1 bit, framebuffer accepts write.
REQ-015 The block SHALL have port frame_done, output, 1 bit, one-cycle end-of-frame pulse.
REQ-016 The block SHALL have port frame_count, output, 8 bits, completed frames.
REQ-017 The block SHALL have port overflow, output, 1 bit, sticky: pixel dropped because FIFO full.
REQ-018 The block SHALL have port range_err, output, 1 bit, sticky: out-of-range coordinate dropped.

Function
REQ-019 Coordinate check: a pixel with pixel_h >= WIDTH or pixel_v >= HEIGHT SHALL be dropped and set range_err; the FIFO is unchanged.
REQ-020 Address computation SHALL be pixel_v*WIDTH + pixel_h, unsigned, truncated to ADDR_W, from the same-cycle inputs.
REQ-021 Push: an in-range ray_done with the FIFO not full SHALL store {address, rtx_pixel} in the FIFO on that edge.
REQ-022 Full FIFO: an in-range ray_done while full and not popping SHALL drop the pixel and set overflow.
REQ-023 Simultaneous push and pop while full SHALL accept the push, with no overflow.
REQ-024 Output stage SHALL be a two-state FSM, EMPTY and HOLD; fb_we = 1 exactly in HOLD.
REQ-025 EMPTY -> HOLD: when the FIFO is non-empty, pop the head into the fb_addr/fb_data registers.
REQ-026 HOLD: fb_addr and fb_data SHALL stay stable until transfer, where transfer = fb_we and fb_ready.
REQ-027 On transfer, if the FIFO is non-empty, the FSM SHALL load the next entry on the same edge and stay in HOLD, giving 1 write/cycle throughput.
REQ-028 On transfer with the FIFO empty, the FSM SHALL go to EMPTY.
REQ-029 Latency: a pixel accepted into an empty FIFO with the FSM in EMPTY SHALL drive fb_we exactly 2 cycles later. (Push at edge N, FSM loads at edge N+1, fb_we high after edge N+1.)
REQ-030 The block SHALL write pixels to the framebuffer in arrival order with no reordering or duplication.
REQ-031 Frame end: on transfer of address (HEIGHT-1)*WIDTH + (WIDTH-1), frame_done SHALL pulse high for the cycle after that edge.
REQ-032 On the same frame-end edge, frame_count SHALL increment, wrapping 255 -> 0.
REQ-033 overflow and range_err SHALL clear only on reset.

Reset
REQ-034 While rst = 0, the FIFO SHALL be empty and the FSM in EMPTY.
REQ-035 While rst = 0, fb_we, frame_done, overflow and range_err SHALL be 0, and fb_addr, fb_data and frame_count SHALL be 0.
REQ-036 Reset assertion mid-write SHALL abandon the held write and the buffered pixels immediately, without waiting for a clock edge.
REQ-037 After rst rises, the first ray_done SHALL be accepted on the first rising edge.

Verification (bench parameters WIDTH=4, HEIGHT=2, FIFO_DEPTH=4, ADDR_W=3)
REQ-038 The bench SHALL cover: single pixel (h=2, v=1, data 16'hF81F), fb_ready=1 -> fb_we one cycle, fb_addr=6, fb_data=16'hF81F, exactly 2 cycles after ray_done.
REQ-039 The bench SHALL cover: fb_ready=0 while 6 back-to-back pixels arrive -> first 5 held (4 FIFO + 1 output register), the 6th is dropped and overflow=1; raising fb_ready writes 5 words in order on consecutive cycles.
REQ-040 The bench SHALL cover: full 8-pixel frame with fb_ready=1 -> addresses 0..7 in order, frame_done pulses once after the addr-7 transfer, frame_count=1.
REQ-041 The bench SHALL cover: pixel h=4, v=0 -> no write, range_err=1, FIFO count unchanged.
REQ-042 The bench SHALL cover: rst=0 asserted while fb_we=1 with 3 entries buffered -> fb_we=0 immediately, no further writes after release, flags and frame_count at 0.
REQ-043 The bench SHALL cover: 256 frames -> frame_count wraps to 0 with 256 frame_done pulses.

Source files
------------

// File: rtl/rtx_fb_writer.sv
// Ray-tracer pixel collector: range-checks pixels, buffers them in a small FIFO and
// streams {address, colour} writes to a framebuffer port with valid/ready handshake.
module rtx_fb_writer #(
    parameter int unsigned WIDTH      = 1280,
    parameter int unsigned HEIGHT     = 720,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       rtx_pixel,
    input  logic [10:0]       pixel_h,
    input  logic [9:0]        pixel_v,
    input  logic              ray_done,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              overflow,
    output logic              range_err
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = ADDR_W + 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // Input qualification and address generation
    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;

    assign w_in_range = (32'(pixel_h) < WIDTH) && (32'(pixel_v) < HEIGHT);
    assign w_addr     = ADDR_W'(32'(pixel_v) * WIDTH + 32'(pixel_h));

    // FIFO storage
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop_full;
    logic [ENTRY_W-1:0] w_head;

    // Output stage
    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [15:0]       r_fb_data;
    logic              w_xfer;
    logic              w_frame_end;
    logic              r_frame_done;
    logic [7:0]        r_frame_count;
    logic              r_overflow;
    logic              r_range_err;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    assign w_xfer = (r_state == ST_HOLD) && fb_ready;
    assign w_pop  = !w_empty && ((r_state == ST_EMPTY) || w_xfer);

    // A full FIFO still accepts when its head leaves on the same edge.
    assign w_push      = ray_done && w_in_range && (!w_full || w_pop);
    assign w_drop_full = ray_done && w_in_range && w_full && !w_pop;

    assign w_frame_end = w_xfer && (r_fb_addr == LAST_ADDR);

    always_comb begin
        w_state_next = r_state;
        if (w_pop) begin
            w_state_next = ST_HOLD;
        end else if (w_xfer) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_addr, rtx_pixel};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_EMPTY;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_fb_addr <= w_head[ENTRY_W-1:16];
                r_fb_data <= w_head[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_range_err   <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_drop_full) begin
                r_overflow <= 1'b1;
            end
            if (ray_done && !w_in_range) begin
                r_range_err <= 1'b1;
            end
        end
    end

    assign fb_we       = (r_state == ST_HOLD);
    assign fb_addr     = r_fb_addr;
    assign fb_data     = r_fb_data;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign overflow    = r_overflow;
    assign range_err   = r_range_err;

endmodule
